// File: rtl/pixel_plane_fetch.sv
// pixel_plane_fetch
//   Turns one scanned {row, column, bit-plane} pixel load into a framebuffer
//   read. When the read data returns, it picks the requested bit plane out of
//   each of the six colour channels and drives the HUB75 rgb lines. It also
//   owns the double-buffer select. A swap requested by the writer takes
//   effect only at a frame boundary.
//
// Ports
//   clk_in, reset_n        clock, synchronous active-low reset
//   pixel_load_en          this cycle's column/row/mask is one pixel load
//   column_address         column being loaded
//   row_address            sub-panel row being loaded
//   brightness_mask        one-hot bit-plane select
//   row_latch              row latch strobe from the scan generator
//   swap_req / swap_ack    writer swap request (level) / one-cycle swap done
//   active_buffer          buffer currently displayed
//   ram_rd_en/addr/data    framebuffer read port, data = {Rt,Gt,Bt,Rb,Gb,Bb}
//   rgb_top, rgb_bot       {R,G,B} plane bits for top and bottom halves
//   rgb_valid              rgb_* carry a fetched pixel
//   err_mask               sticky flag for a load with a non-one-hot mask
//
// Handshake: there is no back-pressure. A load is accepted in every cycle
// where pixel_load_en=1. Its pixel appears with rgb_valid=1 exactly
// RAM_LATENCY+1 cycles later. rgb_valid=0 always comes with blank rgb lines.
module pixel_plane_fetch #(
    parameter int COL_BITS        = 6,
    parameter int ROW_BITS        = 4,
    parameter int BRIGHTNESS_BITS = 8,
    parameter int RAM_LATENCY     = 1
) (
    input  logic                               clk_in,
    input  logic                               reset_n,
    input  logic                               pixel_load_en,
    input  logic [COL_BITS-1:0]                column_address,
    input  logic [ROW_BITS-1:0]                row_address,
    input  logic [BRIGHTNESS_BITS-1:0]         brightness_mask,
    input  logic                               row_latch,
    input  logic                               swap_req,
    output logic                               swap_ack,
    output logic                               active_buffer,
    output logic                               ram_rd_en,
    output logic [ROW_BITS+COL_BITS:0]         ram_rd_addr,
    input  logic [6*BRIGHTNESS_BITS-1:0]       ram_rd_data,
    output logic [2:0]                         rgb_top,
    output logic [2:0]                         rgb_bot,
    output logic                               rgb_valid,
    output logic                               err_mask
);

    localparam int B = BRIGHTNESS_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } swap_state_t;

    swap_state_t state;
    swap_state_t state_next;

    logic frame_end;
    logic do_swap;
    logic mask_onehot;

    logic [RAM_LATENCY-1:0] vld_pipe;
    logic [B-1:0]           mask_pipe [RAM_LATENCY];
    logic [B-1:0]           mask_d;
    logic                   vld_d;
    logic [5:0]             plane_bits;

    // Last plane of the last row closes the frame.
    assign frame_end = row_latch && (row_address == '1) && (brightness_mask == B'(1));
    assign do_swap   = (state == PENDING) && swap_req && frame_end;

    // A one-hot mask is non-zero and has no second set bit.
    assign mask_onehot = (brightness_mask != '0) &&
                         ((brightness_mask & (brightness_mask - B'(1))) == '0);

    // ---------------- swap FSM: state register ----------------
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state         <= IDLE;
            active_buffer <= 1'b0;
        end else begin
            state <= state_next;
            if (do_swap) begin
                active_buffer <= ~active_buffer;
            end
        end
    end

    // ---------------- swap FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (swap_req) state_next = PENDING;
            // Withdrawal wins over a coincident frame end.
            PENDING: if (!swap_req) state_next = IDLE;
                     else if (frame_end) state_next = ACK;
            ACK:     state_next = RELEASE;
            // The request must drop before another swap can be armed.
            RELEASE: if (!swap_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- swap FSM: outputs ----------------
    always_comb begin
        swap_ack = (state == ACK);
    end

    // ---------------- read issue ----------------
    // The address uses the registered buffer select. A load in the toggle
    // cycle therefore still reads the old buffer.
    always_comb begin
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        if (reset_n) begin
            ram_rd_en   = pixel_load_en;
            ram_rd_addr = {active_buffer, row_address, column_address};
        end
    end

    // ---------------- mask / valid alignment with read data ----------------
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                mask_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= pixel_load_en;
            mask_pipe[0] <= brightness_mask;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                mask_pipe[i] <= mask_pipe[i-1];
            end
        end
    end

    assign vld_d  = vld_pipe[RAM_LATENCY-1];
    assign mask_d = mask_pipe[RAM_LATENCY-1];

    // Channel k sits at bits [k*B +: B]. k=5 is Rt and k=0 is Bb.
    always_comb begin
        plane_bits = '0;
        for (int k = 0; k < 6; k++) begin
            plane_bits[k] = |(ram_rd_data[k*B +: B] & mask_d);
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            rgb_valid <= 1'b0;
            rgb_top   <= 3'b000;
            rgb_bot   <= 3'b000;
            err_mask  <= 1'b0;
        end else begin
            rgb_valid <= vld_d;
            rgb_top   <= vld_d ? plane_bits[5:3] : 3'b000;
            rgb_bot   <= vld_d ? plane_bits[2:0] : 3'b000;
            if (pixel_load_en && !mask_onehot) begin
                err_mask <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_plane_fetch.sv
// Bench for pixel_plane_fetch. It has a framebuffer model with one-cycle read
// latency. The driver pushes the expected pixel for every load onto exp_q. A
// monitor on the falling edge pops from exp_q and compares whenever rgb_valid
// is high, and checks for blank lines whenever it is low.
module tb_pixel_plane_fetch;

    localparam int AW = 11;

    logic        clk_in;
    logic        reset_n;
    logic        pixel_load_en;
    logic [5:0]  column_address;
    logic [3:0]  row_address;
    logic [7:0]  brightness_mask;
    logic        row_latch;
    logic        swap_req;
    logic        swap_ack;
    logic        active_buffer;
    logic        ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [47:0] ram_rd_data;
    logic [2:0]  rgb_top;
    logic [2:0]  rgb_bot;
    logic        rgb_valid;
    logic        err_mask;

    pixel_plane_fetch dut (
        .clk_in          (clk_in),
        .reset_n         (reset_n),
        .pixel_load_en   (pixel_load_en),
        .column_address  (column_address),
        .row_address     (row_address),
        .brightness_mask (brightness_mask),
        .row_latch       (row_latch),
        .swap_req        (swap_req),
        .swap_ack        (swap_ack),
        .active_buffer   (active_buffer),
        .ram_rd_en       (ram_rd_en),
        .ram_rd_addr     (ram_rd_addr),
        .ram_rd_data     (ram_rd_data),
        .rgb_top         (rgb_top),
        .rgb_bot         (rgb_bot),
        .rgb_valid       (rgb_valid),
        .err_mask        (err_mask)
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- framebuffer model ----------------
    logic [47:0] mem [2048];
    always @(posedge clk_in) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    // ---------------- scoreboard state ----------------
    logic [5:0] exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic exp_buf = 1'b0;
    logic exp_err = 1'b0;
    logic mon_en  = 1'b0;
    int   ack_cnt = 0;
    int   run_len = 0;
    int   last_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference pixel: a colour bit is lit if any selected plane of that
    // channel is set. Channel order is {Rt,Gt,Bt,Rb,Gb,Bb}, MSB first.
    function automatic logic [5:0] exp_pix(input logic [47:0] w, input logic [7:0] m);
        logic [5:0] r;
        r = '0;
        for (int ch = 0; ch < 6; ch++)
            for (int b = 0; b < 8; b++)
                if (m[b] && w[ch*8 + b]) r[ch] = 1'b1;
        return r;
    endfunction

    function automatic logic is_onehot(input logic [7:0] m);
        int n;
        n = 0;
        for (int b = 0; b < 8; b++) if (m[b]) n++;
        return n == 1;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        if (mon_en && reset_n) begin
            if (swap_ack) ack_cnt++;
            if (rgb_valid) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rgb_valid", 1, 0);
                end else begin
                    check("rgb_pixel", {rgb_top, rgb_bot}, exp_q.pop_front());
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
                check("rgb_blank", {rgb_top, rgb_bot}, 6'b0);
            end
        end
    end

    // ---------------- driver ----------------
    // Called one time step after a rising edge. It drives one cycle of
    // inputs, checks the combinational read request and queues the
    // expected pixel.
    task automatic do_cycle(input logic ld, input logic [5:0] col, input logic [3:0] row,
                            input logic [7:0] m, input logic latch, input logic req);
        logic [AW-1:0] addr;
        pixel_load_en   = ld;
        column_address  = col;
        row_address     = row;
        brightness_mask = m;
        row_latch       = latch;
        swap_req        = req;
        #2;
        check("ram_rd_en", ram_rd_en, ld);
        if (ld) begin
            addr = {exp_buf, row, col};
            check("ram_rd_addr", ram_rd_addr, addr);
            exp_q.push_back(exp_pix(mem[addr], m));
            if (!is_onehot(m)) exp_err = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n, input logic req);
        for (int i = 0; i < n; i++) do_cycle(0, 6'd0, 4'd0, 8'h00, 0, req);
    endtask

    function automatic logic [7:0] rand_plane();
        return 8'(1 << $urandom_range(0, 7));
    endfunction

    // ---------------- main sequence ----------------
    int ack0;
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = {16'($urandom), 32'($urandom)};
        mem[11'h0C5] = {8'h10, 8'h00, 8'hFF, 8'h00, 8'h10, 8'h00};

        // Reset with loads active
        reset_n = 1'b0; pixel_load_en = 1'b1; column_address = 6'd7; row_address = 4'd9;
        brightness_mask = 8'h03; row_latch = 1'b0; swap_req = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ram_rd_en", ram_rd_en, 0);
        check("rst_ram_rd_addr", ram_rd_addr, 0);
        check("rst_rgb", {rgb_top, rgb_bot}, 0);
        check("rst_rgb_valid", rgb_valid, 0);
        check("rst_active_buffer", active_buffer, 0);
        check("rst_err_mask", err_mask, 0);
        check("rst_swap_ack", swap_ack, 0);
        reset_n = 1'b1; swap_req = 1'b0; pixel_load_en = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;

        // Single known pixel
        do_cycle(1, 6'd5, 4'd3, 8'h10, 0, 0);
        do_cycle(0, 6'd0, 4'd0, 8'h00, 0, 0);
        check("t2_rgb_top", rgb_top, 3'b101);
        check("t2_rgb_bot", rgb_bot, 3'b010);
        check("t2_rgb_valid", rgb_valid, 1);
        idle(3, 0);

        // 64 back-to-back loads
        last_run = 0;
        for (int c = 0; c < 64; c++)
            do_cycle(1, 6'(c), 4'($urandom_range(0, 15)), rand_plane(), 0, 0);
        idle(4, 0);
        check("t3_run_length", last_run, 64);

        // Random traffic with one-hot masks
        for (int i = 0; i < 200; i++)
            do_cycle(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
                     4'($urandom_range(0, 15)), rand_plane(), 0, 0);
        idle(4, 0);
        check("err_mask_clear", err_mask, exp_err);

        // Swap with request held, frame end coinciding with a load
        ack0 = ack_cnt;
        do_cycle(0, 6'd0, 4'd0, 8'h00, 0, 1);
        do_cycle(1, 6'd12, 4'd15, 8'h01, 1, 1);
        exp_buf = 1'b1;
        check("t4_active_buffer", active_buffer, 1);
        check("t4_swap_ack_high", swap_ack, 1);
        do_cycle(1, 6'd13, 4'd2, 8'h04, 0, 1);
        check("t4_swap_ack_low", swap_ack, 0);
        idle(2, 1);
        do_cycle(0, 6'd0, 4'd15, 8'h01, 1, 1);
        idle(3, 1);
        check("t4_no_second_swap", active_buffer, 1);
        check("t4_ack_count", ack_cnt - ack0, 1);
        idle(2, 0);

        // Swap request rising in the frame-end cycle
        ack0 = ack_cnt;
        do_cycle(0, 6'd0, 4'd15, 8'h01, 1, 1);
        idle(2, 1);
        check("t5_same_cycle_no_swap", active_buffer, 1);
        do_cycle(0, 6'd0, 4'd15, 8'h02, 1, 1);
        idle(1, 1);
        check("t5_wrong_plane_no_swap", active_buffer, 1);
        do_cycle(0, 6'd0, 4'd15, 8'h01, 1, 1);
        exp_buf = 1'b0;
        check("t5_swap_next_frame", active_buffer, 0);
        idle(2, 1);
        check("t5_ack_count", ack_cnt - ack0, 1);
        idle(2, 0);
        // Request withdrawn before a frame end
        ack0 = ack_cnt;
        idle(2, 1);
        idle(1, 0);
        do_cycle(1, 6'd40, 4'd15, 8'h01, 1, 0);
        idle(3, 0);
        check("t5_withdraw_no_swap", active_buffer, 0);
        check("t5_withdraw_no_ack", ack_cnt - ack0, 0);

        // Non-one-hot mask and zero mask
        do_cycle(1, 6'd21, 4'd6, 8'h03, 0, 0);
        idle(2, 0);
        check("t6_err_mask_set", err_mask, exp_err);
        do_cycle(1, 6'd22, 4'd6, 8'h00, 0, 0);
        do_cycle(0, 6'd0, 4'd0, 8'h00, 0, 0);
        check("t6_zero_mask_valid", rgb_valid, 1);
        check("t6_zero_mask_rgb", {rgb_top, rgb_bot}, 0);
        idle(5, 0);
        check("t6_err_mask_sticky", err_mask, 1);

        // Reset with reads in flight: none of them may surface
        do_cycle(1, 6'd1, 4'd1, 8'h01, 0, 0);
        do_cycle(1, 6'd2, 4'd1, 8'h01, 0, 0);
        reset_n = 1'b0;
        pixel_load_en = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        exp_buf = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        idle(5, 0);
        check("midrst_err_mask", err_mask, exp_err);
        check("midrst_active_buffer", active_buffer, exp_buf);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
